// File: rtl/bomb_pkg.sv
// bomb_pkg: shared types, RGB332 colours and panel geometry for the bomb stage.
// Geometry values are inclusive pixel bounds on the 80x60 display.
package bomb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_DEFUSED  = 2'd2,
        ST_EXPLODED = 2'd3
    } bomb_state_t;

    // RGB332 colours {R[2:0],G[2:0],B[1:0]}
    localparam logic [7:0] COL_BLACK   = 8'h00;
    localparam logic [7:0] COL_FIELD   = 8'h0C;
    localparam logic [7:0] COL_OK      = 8'h1C;
    localparam logic [7:0] COL_RED     = 8'hE0;
    localparam logic [7:0] COL_WHITE   = 8'hFF;
    localparam logic [7:0] COL_BAR     = 8'hF4;
    localparam logic [7:0] COL_PANEL   = 8'hB6;
    localparam logic [7:0] COL_BG      = 8'h49;
    localparam logic [7:0] COL_LED_OFF = 8'h24;

    localparam int unsigned SCR_W = 80;
    localparam int unsigned SCR_H = 60;

    // outer edge of the 4 px border; its inner edge is the panel interior
    localparam int unsigned BRD_X0 = 4,  BRD_X1 = 75, BRD_Y0 = 4,  BRD_Y1 = 55;
    localparam int unsigned PNL_X0 = 8,  PNL_X1 = 71, PNL_Y0 = 8,  PNL_Y1 = 51;
    localparam int unsigned FLD_X0 = 9,  FLD_X1 = 70, FLD_Y0 = 9,  FLD_Y1 = 18;

    localparam int unsigned CELL_X0 = 12, CELL_PITCH = 8, CELL_W = 6;
    localparam int unsigned CELL_Y0 = 11, CELL_Y1 = 16;

    localparam int unsigned BAR_X0 = 9, BAR_Y0 = 22, BAR_Y1 = 25;

    localparam int unsigned LED_X0 = 10, LED_PITCH = 6, LED_W = 4;
    localparam int unsigned LED_Y0 = 48, LED_Y1 = 50;

    // blink period is 32 frames per phase
    localparam int unsigned BLINK_BIT = 5;

    function automatic logic in_rect(input int unsigned px, input int unsigned py,
                                     input int unsigned x0, input int unsigned x1,
                                     input int unsigned y0, input int unsigned y1);
        return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
    endfunction

endpackage

// File: rtl/bomb_countdown.sv
// bomb_countdown: frame prescaler plus seconds-left counter for a bomb stage.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   load            reload sec_left=TIME_SEC and clear the prescaler
//   run             count frame_tick pulses while high
//   frame_tick      one pulse per display frame
//   sec_left        seconds remaining (0 after reset)
//   expired         high in the cycle whose edge takes sec_left from 1 to 0
module bomb_countdown #(
    parameter int unsigned TIME_SEC       = 60,
    parameter int unsigned FRAMES_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       run,
    input  logic       frame_tick,
    output logic [5:0] sec_left,
    output logic       expired
);

    localparam int unsigned FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_SEC - 1);

    logic [FW-1:0] frame_cnt;
    logic          counting;

    assign counting = run && frame_tick && (sec_left != '0);
    // combinational so the FSM reacts on the same edge that ends the countdown
    assign expired  = counting && (frame_cnt == FLAST) && (sec_left == 6'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_left  <= '0;
            frame_cnt <= '0;
        end else if (load) begin
            sec_left  <= 6'(TIME_SEC);
            frame_cnt <= '0;
        end else if (counting) begin
            if (frame_cnt == FLAST) begin
                frame_cnt <= '0;
                sec_left  <= sec_left - 6'd1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bomb_stage_panel.sv
// bomb_stage_panel: defuse FSM, digit entry, countdown and pixel renderer for
// one bomb stage on the 80x60 RGB332 display.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   x, y                scan coordinates
//   frame_tick          one pulse per frame (timer and blink)
//   arm                 start/restart pulse (ignored while armed)
//   key_valid/key_digit BCD key strobe; digits above 9 are ignored
//   answer              BCD answer, digit 0 in the MS nibble
//   color               registered RGB332 pixel, one cycle after x/y
//   state               0 idle, 1 armed, 2 defused, 3 exploded
//   defused, exploded   decoded from state
// Build option: BOMB_STRIKE_LED_EN enables the strike counter and strike LEDs;
// without it any wrong entry explodes immediately.
module bomb_stage_panel
    import bomb_pkg::*;
#(
    parameter int unsigned COORD_W        = 7,
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned TIME_SEC       = 60,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned MAX_STRIKES    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COORD_W-1:0]    x,
    input  logic [COORD_W-1:0]    y,
    input  logic                  frame_tick,
    input  logic                  arm,
    input  logic                  key_valid,
    input  logic [3:0]            key_digit,
    input  logic [4*DIGITS-1:0]   answer,
    output logic [7:0]            color,
    output logic [1:0]            state,
    output logic                  defused,
    output logic                  exploded
);

    localparam logic [2:0] DIG_N = 3'(DIGITS);

    bomb_state_t          st;
    logic [4*DIGITS-1:0]  entry;
    logic [4*DIGITS-1:0]  entry_ins;
    logic [2:0]           count;
    logic [5:0]           blink;
    logic [5:0]           sec_left;
    logic                 expired;
    logic                 key_ok;
    logic                 complete;
    logic                 match;
    logic [7:0]           pix;
`ifdef BOMB_STRIKE_LED_EN
    localparam logic [2:0] MAX_N = 3'(MAX_STRIKES);
    logic [2:0]           strikes;
`endif

    assign state    = st;
    assign defused  = (st == ST_DEFUSED);
    assign exploded = (st == ST_EXPLODED);

    bomb_countdown #(
        .TIME_SEC       (TIME_SEC),
        .FRAMES_PER_SEC (FRAMES_PER_SEC)
    ) u_countdown (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (arm && (st != ST_ARMED)),
        .run        (st == ST_ARMED),
        .frame_tick (frame_tick),
        .sec_left   (sec_left),
        .expired    (expired)
    );

    // buffer as it would be after this key, so the last digit is compared on its own edge
    always_comb begin
        key_ok    = key_valid && (key_digit <= 4'd9);
        entry_ins = entry;
        if (count < DIG_N)
            entry_ins[4*(DIGITS-1-32'(count)) +: 4] = key_digit;
        complete  = key_ok && (count == DIG_N - 3'd1);
        match     = (entry_ins == answer);
    end

    always_comb begin
        int unsigned px, py, cx0;
        logic        cell_hit, cell_fill, cell_edge;
        logic        led_hit, led_on;
        px        = 32'(x);
        py        = 32'(y);
        cx0       = 0;
        cell_hit  = 1'b0;
        cell_fill = 1'b0;
        cell_edge = 1'b0;
        led_hit   = 1'b0;
        led_on    = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            cx0 = CELL_X0 + CELL_PITCH * i;
            if (in_rect(px, py, cx0, cx0 + CELL_W - 1, CELL_Y0, CELL_Y1)) begin
                cell_hit  = 1'b1;
                cell_fill = (i < 32'(count));
                cell_edge = (px == cx0) || (px == cx0 + CELL_W - 1) ||
                            (py == CELL_Y0) || (py == CELL_Y1);
            end
        end
`ifdef BOMB_STRIKE_LED_EN
        for (int unsigned k = 0; k < MAX_STRIKES; k++) begin
            if (in_rect(px, py, LED_X0 + LED_PITCH * k, LED_X0 + LED_PITCH * k + LED_W - 1,
                        LED_Y0, LED_Y1)) begin
                led_hit = 1'b1;
                led_on  = (k < 32'(strikes));
            end
        end
`endif
        pix = COL_BG;
        if (px >= SCR_W || py >= SCR_H)
            pix = COL_BG;
        else if (in_rect(px, py, BRD_X0, BRD_X1, BRD_Y0, BRD_Y1) &&
                 !in_rect(px, py, PNL_X0, PNL_X1, PNL_Y0, PNL_Y1))
            pix = COL_BLACK;
        else if (in_rect(px, py, FLD_X0, FLD_X1, FLD_Y0, FLD_Y1)) begin
            case (st)
                ST_DEFUSED:  pix = COL_OK;
                ST_EXPLODED: pix = blink[BLINK_BIT] ? COL_BLACK : COL_RED;
                default:     pix = COL_FIELD;
            endcase
        end
        // cells lie inside the field, so with this geometry the field colour wins
        else if (cell_hit && (cell_fill || cell_edge))
            pix = cell_fill ? COL_WHITE : COL_BLACK;
        else if (py >= BAR_Y0 && py <= BAR_Y1 && px >= BAR_X0 &&
                 px <= BAR_X0 - 1 + 32'(sec_left))
            pix = COL_BAR;
        else if (led_hit)
            pix = led_on ? COL_RED : COL_LED_OFF;
        else if (in_rect(px, py, PNL_X0, PNL_X1, PNL_Y0, PNL_Y1))
            pix = COL_PANEL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st    <= ST_IDLE;
            entry <= '0;
            count <= '0;
            blink <= '0;
            color <= '0;
`ifdef BOMB_STRIKE_LED_EN
            strikes <= '0;
`endif
        end else begin
            color <= pix;
            if (frame_tick)
                blink <= blink + 6'd1;
            case (st)
                ST_ARMED: begin
                    if (complete && match) begin
                        st    <= ST_DEFUSED;
                        entry <= entry_ins;
                        count <= count + 3'd1;
                    end else if (complete) begin
                        entry <= '0;
                        count <= '0;
`ifdef BOMB_STRIKE_LED_EN
                        strikes <= strikes + 3'd1;
                        if ((strikes + 3'd1 == MAX_N) || expired)
                            st <= ST_EXPLODED;
`else
                        st <= ST_EXPLODED;
`endif
                    end else begin
                        if (key_ok) begin
                            entry <= entry_ins;
                            count <= count + 3'd1;
                        end
                        if (expired)
                            st <= ST_EXPLODED;
                    end
                end
                default: begin
                    if (arm) begin
                        st    <= ST_ARMED;
                        entry <= '0;
                        count <= '0;
`ifdef BOMB_STRIKE_LED_EN
                        strikes <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/bomb_stage_panel.md
# bomb_stage_panel

Clocked, parametrised bomb-stage panel for the 80×60 RGB332 display. It owns the stage's defuse state machine, digit-entry buffer, countdown timer and strike counter, and renders the panel pixel-by-pixel from the scan coordinates. It sits between the keypad/frame-timing logic and the display pixel mux, and is instantiated once per stage with stage-specific parameters.

## Interface
Parameters:
- `COORD_W`, 7: width of `x`/`y`.
- `DIGITS`, 4: answer length in decimal digits (1–6).
- `TIME_SEC`, 60: countdown length in seconds (1–62).
- `FRAMES_PER_SEC`, 60: `frame_tick` pulses per second.
- `MAX_STRIKES`, 3: wrong entries tolerated before explosion (1–7; only with strike feature).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `x` in COORD_W: pixel column.
- `y` in COORD_W: pixel row.
- `frame_tick` in 1: one-cycle pulse per frame.
- `arm` in 1: one-cycle pulse that starts or restarts the stage.
- `key_valid` in 1: one-cycle key strobe.
- `key_digit` in 4: BCD digit, sampled when `key_valid`.
- `answer` in 4*DIGITS: BCD answer, digit 0 in the MS nibble; stable while armed.
- `color` out 8: {R[2:0],G[2:0],B[1:0]}, registered.
- `state` out 2: IDLE=0, ARMED=1, DEFUSED=2, EXPLODED=3.
- `defused`, `exploded` out 1: decoded from `state`.

## Operation
- FSM states: IDLE, ARMED, DEFUSED, EXPLODED.
  - IDLE→ARMED on `arm`: clear entry buffer, count and strikes; load `sec_left=TIME_SEC`, `frame_cnt=0`.
  - `arm` in DEFUSED or EXPLODED restarts exactly like IDLE. `arm` in ARMED is ignored.
- Entry, ARMED only. `key_valid` with `key_digit≤9` appends the digit at index `count` and increments `count`. Digits >9 are ignored.
  - When `count` reaches DIGITS, the buffer is compared with `answer` on that same edge.
  - Match → DEFUSED.
  - Mismatch → strike, buffer and count clear.
- Countdown, ARMED only. `frame_tick` increments `frame_cnt`. At FRAMES_PER_SEC-1, `frame_cnt` wraps to 0 and `sec_left` decrements.
  - `sec_left` reaching 0 → EXPLODED.
- Simultaneous events: a completing correct digit and timer expiry in the same cycle → DEFUSED. A wrong completion and expiry in the same cycle → EXPLODED.
- Rendering, first match wins:
  - Border (x 4–75, y 4–55, 4 px thick): black 00.
  - Display field (x 9–70, y 9–18) background by state: IDLE 0x0C, ARMED 0x0C, DEFUSED 0x1C, EXPLODED alternates 0xE0/0x00 every 32 frames.
  - Digit cells, inside the field: i<DIGITS at x 12+8i…17+8i, y 11–16; filled 0xFF if i<count, else 0x00 outline.
  - Timer bar: y 22–25, x 9…8+sec_left, colour 0xF4.
  - Panel interior (x 8–71, y 8–51): 0xB6.
  - Elsewhere: 0x49.
- Coordinates ≥80 or ≥60 render background 0x49.

## Timing
- `color` = f(x,y,state) sampled at edge N, visible after edge N: 1-cycle latency, no other pipelining.
- `state`, `defused`, `exploded` are registered and change on the edge that processes the event.
- Reset values: `color`=0x00, `state`=IDLE, `defused`=0, `exploded`=0. Internal: count=0, strikes=0, sec_left=0, frame_cnt=0, blink counter=0.
- Reset mid-stage aborts to IDLE on the next edge with `rst_n` low.
- Blink counter runs on `frame_tick` in every state.

## Configuration
- `BOMB_STRIKE_LED_EN` defined:
  - Mismatches increment `strikes`; the MAX_STRIKES-th strike → EXPLODED.
  - Strike LEDs are drawn at y 48–50, x 10+6k…13+6k for k<MAX_STRIKES. Colour 0xE0 if k<strikes, else 0x24.
- Undefined: any mismatch → EXPLODED immediately, no strike register, no LEDs drawn.

## Structure
- Package `bomb_pkg`:
  - `bomb_state_t` enum.
  - RGB332 colour constants.
  - Panel, field, cell, bar and LED geometry localparams.
- Sub-module `bomb_countdown`: frame prescaler plus `sec_left` counter. Inputs: `load`, `run`, `frame_tick`. Outputs: `sec_left`, `expired` (one-cycle pulse).
- Top level holds the FSM, entry buffer, comparator and the registered pixel mux.

## Test plan
- Reset, then probe (20,12) → `color`=0x0C, `state`=0; probe (5,5) → 0x00; probe (100,100) → 0x49.
- DIGITS=4, answer 0x1234; `arm`, keys 1,2,3,4 → `defused`=1 on the 4th key's edge; (20,12) → 0x1C.
- With macro and MAX_STRIKES=3: three wrong 4-digit entries → strikes 1,2 then EXPLODED on the third. LED k=0 at (11,49) → 0xE0 after the first strike.
- TIME_SEC=2, FRAMES_PER_SEC=4: `arm`, then 8 `frame_tick` → EXPLODED on the 8th. Bar pixel (10,23) is 0xF4 before and 0xB6 after.
- Correct final key coinciding with the expiring `frame_tick` → DEFUSED. Then `arm` → ARMED with count=0 and sec_left=TIME_SEC.
- `key_digit`=0xA while ARMED → count unchanged; `rst_n` low mid-entry → IDLE and `color`=0x00 next edge.
